approx_mult_arb: RTL and testbench

Round-robin arbiter and two-stage pipeline controller that shares one 8x8 unsigned l=4 approximate multiplier core (the "exchange" family: upper nibble of x exact, lower nibble approximated) among NREQ requesters. Each requester selects approximate or exact mode per transaction. Results return on a single valid/ready output channel tagged with the requester index. The block sits between the processing-element request ports and the shared multiplier core.

---
 rtl/approx_mult_arb.sv | 193 +++++++++++++++++++
 tb/tb_approx_mult_arb.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_mult_arb.sv
// approx_mult_arb: round-robin arbiter feeding a two-stage pipeline around
// one shared 8x8 multiplier. Each transaction is either exact or uses the
// l=4 exchange approximation. Results leave on a valid/ready channel tagged
// with the index of the requester that issued them.
module approx_mult_arb #(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [8*NREQ-1:0]   req_x,
    input  logic [8*NREQ-1:0]   req_y,
    input  logic [NREQ-1:0]     req_exact,
    output logic [NREQ-1:0]     req_ready,
    output logic                out_valid,
    output logic [15:0]         out_z,
    output logic [ID_W-1:0]     out_id,
    output logic                out_exact,
    input  logic                out_ready,
    output logic                busy
);

    // Exchange-family approximation: exact upper nibble of x, lower nibble
    // replaced by a fixed set of correction bits at weights 2^8..2^10.
    function automatic logic [15:0] approx_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0]  pp0, pp1, pp2, pp3;
        logic [15:0] acc;
        pp0 = y & {8{x[0]}};
        pp1 = y & {8{x[1]}};
        pp2 = y & {8{x[2]}};
        pp3 = y & {8{x[3]}};
        acc = ({8'd0, y} * {12'd0, x[7:4]}) << 4;
        acc = acc + {7'd0, pp0[7] | pp1[6], 8'd0};
        acc = acc + {7'd0, pp2[6] ^ pp3[5], 8'd0};
        acc = acc + {7'd0, pp1[7], 8'd0};
        acc = acc + {7'd0, pp2[5] | pp3[4], 8'd0};
        acc = acc + {6'd0, pp2[6] & pp3[5], 9'd0};
        acc = acc + {6'd0, pp2[7] & pp3[6], 9'd0};
        acc = acc + {6'd0, pp2[7] | pp3[6], 9'd0};
        acc = acc + {5'd0, pp3[7], 10'd0};
        return acc;
    endfunction

    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic            s1_v_q, s1_v_d;
    logic [7:0]      s1_x_q, s1_x_d;
    logic [7:0]      s1_y_q, s1_y_d;
    logic            s1_exact_q, s1_exact_d;
    logic [ID_W-1:0] s1_id_q, s1_id_d;
    logic            s2_v_q, s2_v_d;
    logic [15:0]     s2_z_q, s2_z_d;
    logic [ID_W-1:0] s2_id_q, s2_id_d;
    logic            s2_exact_q, s2_exact_d;

    logic [NREQ-1:0] grant_s;
    logic [ID_W-1:0] grant_id_s;
    logic            grant_any_s;
    logic            s1_load_ok_s;
    logic            s2_load_ok_s;
    logic            accept_s;
    logic [ID_W:0]   rr_nxt_s;
    logic [15:0]     s1_z_s;

    // Round-robin search: first valid requester at or after rr_ptr_q
    always_comb begin : arb_comb
        logic [ID_W:0] cand;
        cand        = '0;
        grant_s     = '0;
        grant_id_s  = '0;
        grant_any_s = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NREQ)) begin
                cand = cand - (ID_W+1)'(NREQ);
            end else begin
                cand = cand;
            end
            if (!grant_any_s && req_valid[cand[ID_W-1:0]]) begin
                grant_any_s                 = 1'b1;
                grant_s[cand[ID_W-1:0]]     = 1'b1;
                grant_id_s                  = cand[ID_W-1:0];
            end else begin
                grant_any_s = grant_any_s;
            end
        end
    end

    // Flow control, handshake and next-state for pointer and both stages
    always_comb begin
        s2_load_ok_s = !s2_v_q | out_ready;
        s1_load_ok_s = !s1_v_q | s2_load_ok_s;
        // Ready is forced low while reset is asserted, independent of state.
        req_ready    = grant_s & {NREQ{s1_load_ok_s & rst_n}};
        accept_s     = grant_any_s & s1_load_ok_s & rst_n;
        rr_nxt_s     = {1'b0, grant_id_s} + (ID_W+1)'(1);

        rr_ptr_d   = rr_ptr_q;
        s1_v_d     = s1_v_q;
        s1_x_d     = s1_x_q;
        s1_y_d     = s1_y_q;
        s1_exact_d = s1_exact_q;
        s1_id_d    = s1_id_q;
        s2_v_d     = s2_v_q;
        s2_z_d     = s2_z_q;
        s2_id_d    = s2_id_q;
        s2_exact_d = s2_exact_q;

        if (accept_s) begin
            if (rr_nxt_s == (ID_W+1)'(NREQ)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = rr_nxt_s[ID_W-1:0];
            end
        end else begin
            rr_ptr_d = rr_ptr_q;
        end

        // s1 refills in the same cycle s2 takes its contents, so a full
        // pipeline with out_ready high streams without bubbles.
        if (s1_load_ok_s) begin
            s1_v_d = accept_s;
            if (accept_s) begin
                s1_x_d     = req_x[{grant_id_s, 3'b000} +: 8];
                s1_y_d     = req_y[{grant_id_s, 3'b000} +: 8];
                s1_exact_d = req_exact[grant_id_s];
                s1_id_d    = grant_id_s;
            end else begin
                s1_id_d = s1_id_q;
            end
        end else begin
            s1_v_d = s1_v_q;
        end

        // s2 data only changes when a real transaction moves in, so the
        // outputs hold steady while stalled.
        if (s2_load_ok_s) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                s2_z_d     = s1_z_s;
                s2_id_d    = s1_id_q;
                s2_exact_d = s1_exact_q;
            end else begin
                s2_id_d = s2_id_q;
            end
        end else begin
            s2_v_d = s2_v_q;
        end
    end

    // Shared multiplier core evaluated on the s1 registers
    always_comb begin
        if (s1_exact_q) begin
            s1_z_s = {8'd0, s1_x_q} * {8'd0, s1_y_q};
        end else begin
            s1_z_s = approx_mul(s1_x_q, s1_y_q);
        end
    end

    // State registers; reset drops every in-flight transaction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q   <= '0;
            s1_v_q     <= 1'b0;
            s1_x_q     <= 8'd0;
            s1_y_q     <= 8'd0;
            s1_exact_q <= 1'b0;
            s1_id_q    <= '0;
            s2_v_q     <= 1'b0;
            s2_z_q     <= 16'd0;
            s2_id_q    <= '0;
            s2_exact_q <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            s1_v_q     <= s1_v_d;
            s1_x_q     <= s1_x_d;
            s1_y_q     <= s1_y_d;
            s1_exact_q <= s1_exact_d;
            s1_id_q    <= s1_id_d;
            s2_v_q     <= s2_v_d;
            s2_z_q     <= s2_z_d;
            s2_id_q    <= s2_id_d;
            s2_exact_q <= s2_exact_d;
        end
    end

    assign out_valid = s2_v_q;
    assign out_z     = s2_z_q;
    assign out_id    = s2_id_q;
    assign out_exact = s2_exact_q;
    assign busy      = s1_v_q | s2_v_q;

endmodule

// File: tb/tb_approx_mult_arb.sv
// Bench for approx_mult_arb: table of hand-computed products, directed
// reset / fairness / backpressure sequences, and a random soak, all feeding
// one in-order scoreboard.
module tb_approx_mult_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_x;
    logic [31:0] req_y;
    logic [3:0]  req_exact;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic [15:0] out_z;
    logic [1:0]  out_id;
    logic        out_exact;
    logic        out_ready;
    logic        busy;

    approx_mult_arb #(.NREQ(4), .ID_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_exact (req_exact),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_z     (out_z),
        .out_id    (out_id),
        .out_exact (out_exact),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  id;
        logic        ex;
        logic [15:0] z;
    } exp_t;

    typedef struct {
        logic [1:0]  id;
        logic [7:0]  x;
        logic [7:0]  y;
        logic        ex;
        logic [15:0] z;
    } vec_t;

    exp_t        sb_q[$];
    vec_t        tbl[10];
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_acc = 0;
    logic [3:0]  acc_mask = 4'b0000;

    // Reference: exact product, or the approximation as a weighted count
    function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y, input logic ex);
        logic [7:0] p0, p1, p2, p3;
        int r;
        if (ex) begin
            r = int'(x) * int'(y);
            return r[15:0];
        end
        p0 = x[0] ? y : 8'h00;
        p1 = x[1] ? y : 8'h00;
        p2 = x[2] ? y : 8'h00;
        p3 = x[3] ? y : 8'h00;
        r = int'(y) * int'(x[7:4]) * 16;
        r += 256 * (int'(p0[7] | p1[6]) + int'(p2[6] ^ p3[5]) + int'(p1[7]) + int'(p2[5] | p3[4]));
        r += 512 * (int'(p2[6] & p3[5]) + int'(p2[7] & p3[6]) + int'(p2[7] | p3[6]));
        r += 1024 * int'(p3[7]);
        return r[15:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Observe the handshakes about to happen at the next rising edge
    task automatic sb_sample();
        exp_t e;
        chk("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_unexpected: got result id %0d z %0h expected none", out_id, out_z);
            end else begin
                e = sb_q.pop_front();
                chk("sb_z", 32'(out_z), 32'(e.z));
                chk("sb_id", 32'(out_id), 32'(e.id));
                chk("sb_exact", 32'(out_exact), 32'(e.ex));
            end
        end
        acc_mask = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                e.id = 2'(i);
                e.ex = req_exact[i];
                e.z  = ref_mul(req_x[8*i +: 8], req_y[8*i +: 8], req_exact[i]);
                sb_q.push_back(e);
                acc_mask[i] = 1'b1;
                n_acc++;
            end
        end
    endtask

    task automatic half();
        @(negedge clk);
        sb_sample();
    endtask

    task automatic edge_();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        half();
        edge_();
    endtask

    task automatic set_req(input int i, input logic [7:0] x, input logic [7:0] y, input logic ex);
        req_x[8*i +: 8] = x;
        req_y[8*i +: 8] = y;
        req_exact[i]    = ex;
    endtask

    initial begin
        logic [15:0] held_z;
        logic [1:0]  held_id;
        int          n0;
        int          guard;

        tbl[0] = '{2'd0, 8'h0F, 8'hFF, 1'b0, 16'h0D00};
        tbl[1] = '{2'd0, 8'h30, 8'h05, 1'b0, 16'h00F0};
        tbl[2] = '{2'd0, 8'h0F, 8'hFF, 1'b1, 16'h0EF1};
        tbl[3] = '{2'd1, 8'hFF, 8'hFF, 1'b0, 16'hFC10};
        tbl[4] = '{2'd2, 8'hFF, 8'hFF, 1'b1, 16'hFE01};
        tbl[5] = '{2'd3, 8'h01, 8'h80, 1'b0, 16'h0100};
        tbl[6] = '{2'd1, 8'h01, 8'h80, 1'b1, 16'h0080};
        tbl[7] = '{2'd2, 8'h08, 8'h80, 1'b0, 16'h0400};
        tbl[8] = '{2'd3, 8'h04, 8'h40, 1'b0, 16'h0100};
        tbl[9] = '{2'd0, 8'h00, 8'hAB, 1'b0, 16'h0000};

        // Power-up reset with every requester asking
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        req_x     = 32'd0;
        req_y     = 32'd0;
        req_exact = 4'b0000;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_z", 32'(out_z), 32'd0);
        chk("rst_out_id", 32'(out_id), 32'd0);
        chk("rst_out_exact", 32'(out_exact), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        req_valid = 4'b0000;
        rst_n     = 1'b1;
        edge_();

        // Table: one isolated request each, result visible in the cycle
        // ending at the second edge after the accept edge
        out_ready = 1'b1;
        for (int v = 0; v < 10; v++) begin
            set_req(int'(tbl[v].id), tbl[v].x, tbl[v].y, tbl[v].ex);
            req_valid = 4'b0000;
            req_valid[tbl[v].id] = 1'b1;
            half();
            chk("tbl_ready", 32'(req_ready), 32'(4'b0001 << tbl[v].id));
            edge_();
            req_valid = 4'b0000;
            half();
            chk("tbl_early", 32'(out_valid), 32'd0);
            edge_();
            half();
            chk("tbl_valid", 32'(out_valid), 32'd1);
            chk("tbl_z", 32'(out_z), 32'(tbl[v].z));
            chk("tbl_id", 32'(out_id), 32'(tbl[v].id));
            chk("tbl_exact", 32'(out_exact), 32'(tbl[v].ex));
            edge_();
        end

        // Fill both stages, then reset mid-stream
        for (int i = 0; i < 4; i++) begin
            set_req(i, 8'(8'h13 + 8'h10 * i), 8'(8'h21 + i), 1'(i));
        end
        req_valid = 4'b1111;
        out_ready = 1'b0;
        repeat (3) tick();
        chk("fill_valid", 32'(out_valid), 32'd1);
        chk("fill_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_z", 32'(out_z), 32'd0);
        chk("mid_rst_id", 32'(out_id), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        sb_q.delete();
        edge_();
        rst_n     = 1'b1;
        out_ready = 1'b1;

        // Fairness: all four valid, grants rotate from 0 without gaps
        for (int c = 0; c < 12; c++) begin
            half();
            chk("rr_grant", 32'(req_ready), 32'(4'b0001 << (c % 4)));
            if (c >= 2) begin
                chk("rr_out_valid", 32'(out_valid), 32'd1);
                chk("rr_out_id", 32'(out_id), 32'((c - 2) % 4));
            end
            edge_();
        end
        req_valid = 4'b0000;
        repeat (3) tick();
        chk("rr_drained", 32'(sb_q.size()), 32'd0);
        chk("rr_idle", 32'(busy), 32'd0);

        // Backpressure: two requesters, output stalled for five cycles
        set_req(1, 8'h5A, 8'h3C, 1'b0);
        set_req(3, 8'hC3, 8'h77, 1'b1);
        req_valid = 4'b1010;
        out_ready = 1'b0;
        n0        = n_acc;
        held_z    = 16'd0;
        held_id   = 2'd0;
        for (int c = 0; c < 5; c++) begin
            half();
            if (c >= 2) begin
                chk("bp_ready_low", 32'(req_ready), 32'd0);
                chk("bp_out_valid", 32'(out_valid), 32'd1);
                if (c == 2) begin
                    held_z  = out_z;
                    held_id = out_id;
                end else begin
                    chk("bp_z_stable", 32'(out_z), 32'(held_z));
                    chk("bp_id_stable", 32'(out_id), 32'(held_id));
                end
            end
            edge_();
        end
        chk("bp_accepts", 32'(n_acc - n0), 32'd2);
        req_valid = 4'b0000;
        out_ready = 1'b1;
        repeat (3) tick();
        chk("bp_drained", 32'(sb_q.size()), 32'd0);
        chk("bp_idle", 32'(busy), 32'd0);

        // Random soak: pending requests held until accepted, occasional drops
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!req_valid[i] || acc_mask[i]) begin
                    req_valid[i] = ($urandom_range(0, 99) < 60);
                    set_req(i, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                            1'($urandom_range(0, 1)));
                end else if ($urandom_range(0, 99) < 3) begin
                    req_valid[i] = 1'b0;
                end else begin
                    req_valid[i] = 1'b1;
                end
            end
            out_ready = ($urandom_range(0, 99) < 70);
            tick();
        end
        req_valid = 4'b0000;
        out_ready = 1'b1;
        guard     = 0;
        while ((busy || sb_q.size() != 0) && guard < 20) begin
            tick();
            guard++;
        end
        chk("soak_drained", 32'(sb_q.size()), 32'd0);
        chk("soak_idle", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
